// File: rtl/sync_native_fifo_pkg.sv
// Shared types and helpers for sync_native_fifo: pointer compares, reset dout value, occupancy type.
package sync_native_fifo_pkg;

    // Wide unsigned carrier for pointers/counts; callers zero-extend into it.
    typedef logic [31:0] occ_t;

    localparam int unsigned MAX_DATA_W = 64;
    localparam logic [MAX_DATA_W-1:0] RST_DOUT = '0;

    function automatic logic ptr_empty(occ_t wp, occ_t rp);
        return wp == rp;
    endfunction

    // Address bits match and the wrap bit (bit aw) differs.
    function automatic logic ptr_full(occ_t wp, occ_t rp, int unsigned aw);
        return (wp ^ rp) == (occ_t'(1) << aw);
    endfunction

endpackage

// File: rtl/sync_native_fifo_if.sv
// Native FIFO port bundle: master drives writes/reads, slave (the FIFO) responds.
// prog_full exists only with SYNC_NATIVE_FIFO_PROG_FULL_EN.
interface sync_native_fifo_if #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] din;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   data_count;
    logic              overflow;
    logic              underflow;
`ifdef SYNC_NATIVE_FIFO_PROG_FULL_EN
    logic              prog_full;

    modport master (output din, wr_en, rd_en,
                    input  dout, valid, full, empty, data_count, overflow, underflow, prog_full);
    modport slave  (input  din, wr_en, rd_en,
                    output dout, valid, full, empty, data_count, overflow, underflow, prog_full);
`else
    modport master (output din, wr_en, rd_en,
                    input  dout, valid, full, empty, data_count, overflow, underflow);
    modport slave  (input  din, wr_en, rd_en,
                    output dout, valid, full, empty, data_count, overflow, underflow);
`endif
endinterface

// File: rtl/sync_native_fifo_ram.sv
// Simple dual-port RAM, sync write, sync read with enable; only the read register is reset.
module sync_native_fifo_ram
    import sync_native_fifo_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              srst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    // Output register maps onto the BRAM output latch sync reset.
    always_ff @(posedge clk) begin
        if (!srst_n)   rdata_q <= RST_DOUT[DATA_W-1:0];
        else if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sync_native_fifo.sv
// Single-clock standard-read FIFO with registered flags, occupancy and error pulses.
// Optional prog_full output under SYNC_NATIVE_FIFO_PROG_FULL_EN.
module sync_native_fifo
    import sync_native_fifo_pkg::*;
#(
    parameter int DATA_W           = 4,
    parameter int DEPTH            = 16,
    parameter int PROG_FULL_THRESH = DEPTH - 2
) (
    input  logic                clk,
    input  logic                srst_n,
    sync_native_fifo_if.slave   bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PW     = ADDR_W + 1;
    localparam bit CFG_OK = (DEPTH >= 4) && ((DEPTH & (DEPTH - 1)) == 0) &&
                            (DATA_W >= 1) && (DATA_W <= int'(MAX_DATA_W)) &&
                            (PROG_FULL_THRESH >= 0) && (PROG_FULL_THRESH <= DEPTH);

    if (!CFG_OK) begin : g_cfg_err
        $error("sync_native_fifo: illegal DEPTH/DATA_W/PROG_FULL_THRESH");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          valid_q, ovf_q, udf_q;
    logic          wr_acc, rd_acc;
    logic [DATA_W-1:0] rdata;

    // Flags are pre-edge state: no bypass in either direction.
    assign wr_acc = bus.wr_en & ~full_q  & srst_n;
    assign rd_acc = bus.rd_en & ~empty_q & srst_n;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d = rd_ptr_q + PW'(rd_acc);
        cnt_d    = cnt_q;
        if (wr_acc && !rd_acc)      cnt_d = cnt_q + PW'(1);
        else if (rd_acc && !wr_acc) cnt_d = cnt_q - PW'(1);
        full_d   = ptr_full(occ_t'(wr_ptr_d), occ_t'(rd_ptr_d), ADDR_W);
        empty_d  = ptr_empty(occ_t'(wr_ptr_d), occ_t'(rd_ptr_d));
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            valid_q  <= rd_acc;
            ovf_q    <= bus.wr_en & full_q;
            udf_q    <= bus.rd_en & empty_q;
        end
    end

    sync_native_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .srst_n  (srst_n),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (bus.din),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rdata)
    );

`ifdef SYNC_NATIVE_FIFO_PROG_FULL_EN
    logic pfull_q;
    always_ff @(posedge clk) begin
        if (!srst_n) pfull_q <= 1'b0;
        else         pfull_q <= occ_t'(cnt_d) >= occ_t'(PROG_FULL_THRESH);
    end
    assign bus.prog_full = pfull_q;
`endif

    assign bus.dout       = rdata;
    assign bus.valid      = valid_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.data_count = cnt_q;
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = udf_q;
endmodule

// File: tb/tb_sync_native_fifo.sv
// Directed bench for sync_native_fifo (DATA_W=4, DEPTH=16) with hand-computed expectations.
module tb_sync_native_fifo;
    logic clk = 1'b0;
    logic srst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    sync_native_fifo_if #(.DATA_W(4), .DEPTH(16)) bus ();

    sync_native_fifo #(.DATA_W(4), .DEPTH(16)) dut (
        .clk    (clk),
        .srst_n (srst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one edge, then settle so registered outputs are visible.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic w, input logic r, input logic [3:0] d);
        bus.wr_en = w;
        bus.rd_en = r;
        bus.din   = d;
    endtask

    initial begin
        srst_n = 1'b0;
        set(0, 0, 4'h0);
        step(); step();
        srst_n = 1'b1;
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full",  32'(bus.full), 0);
        chk("rst_cnt",   32'(bus.data_count), 0);
        chk("rst_dout",  32'(bus.dout), 0);
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_ovf_udf", {30'd0, bus.overflow, bus.underflow}, 0);

        // Two writes, idle, two reads.
        set(1, 0, 4'b1001); step(); chk("w1_cnt", 32'(bus.data_count), 1);
        chk("w1_empty", 32'(bus.empty), 0);
        set(1, 0, 4'b1110); step(); chk("w2_cnt", 32'(bus.data_count), 2);
        set(0, 0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            step(); chk("idle_cnt", 32'(bus.data_count), 2);
        end
        chk("idle_valid", 32'(bus.valid), 0);
        set(0, 1, 4'h0); step();
        chk("r1_dout", 32'(bus.dout), 4'b1001); chk("r1_valid", 32'(bus.valid), 1);
        chk("r1_cnt", 32'(bus.data_count), 1);
        step();
        chk("r2_dout", 32'(bus.dout), 4'b1110); chk("r2_valid", 32'(bus.valid), 1);
        chk("r2_cnt", 32'(bus.data_count), 0); chk("r2_empty", 32'(bus.empty), 1);
        set(0, 0, 4'h0); step();
        chk("hold_valid", 32'(bus.valid), 0); chk("hold_dout", 32'(bus.dout), 4'b1110);

        // Fill, overflow, drain.
        for (int i = 0; i < 16; i++) begin
            set(1, 0, 4'(i)); step();
            chk("fill_cnt", 32'(bus.data_count), 32'(i + 1));
`ifdef SYNC_NATIVE_FIFO_PROG_FULL_EN
            chk("fill_pfull", 32'(bus.prog_full), (i + 1 >= 14) ? 1 : 0);
`endif
        end
        chk("fill_full", 32'(bus.full), 1);
        chk("fill_ovf0", 32'(bus.overflow), 0);
        set(1, 0, 4'hA); step();
        chk("ovf_pulse", 32'(bus.overflow), 1); chk("ovf_cnt", 32'(bus.data_count), 16);
        set(0, 0, 4'h0); step();
        chk("ovf_clear", 32'(bus.overflow), 0);
        for (int i = 0; i < 16; i++) begin
            set(0, 1, 4'h0); step();
            chk("drain_dout", 32'(bus.dout), 32'(i)); chk("drain_valid", 32'(bus.valid), 1);
        end
        chk("drain_empty", 32'(bus.empty), 1); chk("drain_full", 32'(bus.full), 0);
        set(0, 0, 4'h0); step();

        // Read while empty.
        set(0, 1, 4'h0); step();
        chk("udf_pulse", 32'(bus.underflow), 1); chk("udf_valid", 32'(bus.valid), 0);
        chk("udf_dout", 32'(bus.dout), 4'hF);
        set(0, 0, 4'h0); step();
        chk("udf_clear", 32'(bus.underflow), 0);

        // Simultaneous at full.
        for (int i = 0; i < 16; i++) begin
            set(1, 0, 4'(i)); step();
        end
        set(1, 1, 4'hA); step();
        chk("sim16_ovf", 32'(bus.overflow), 1); chk("sim16_cnt", 32'(bus.data_count), 15);
        chk("sim16_dout", 32'(bus.dout), 0); chk("sim16_full", 32'(bus.full), 0);
        for (int i = 1; i < 16; i++) begin
            set(0, 1, 4'h0); step();
            chk("sim16_drain", 32'(bus.dout), 32'(i));
        end
        chk("sim16_empty", 32'(bus.empty), 1);

        // Simultaneous at empty.
        set(1, 1, 4'h5); step();
        chk("sim0_udf", 32'(bus.underflow), 1); chk("sim0_cnt", 32'(bus.data_count), 1);
        chk("sim0_valid", 32'(bus.valid), 0);
        set(0, 1, 4'h0); step();
        chk("sim0_dout", 32'(bus.dout), 5); chk("sim0_empty", 32'(bus.empty), 1);

        // Simultaneous at count 5.
        for (int i = 6; i <= 10; i++) begin
            set(1, 0, 4'(i)); step();
        end
        set(1, 1, 4'hB); step();
        chk("sim5_cnt", 32'(bus.data_count), 5); chk("sim5_dout", 32'(bus.dout), 6);
        chk("sim5_flags", {30'd0, bus.overflow, bus.underflow}, 0);
        for (int i = 7; i <= 11; i++) begin
            set(0, 1, 4'h0); step();
            chk("sim5_drain", 32'(bus.dout), 32'(i));
        end
        chk("sim5_empty", 32'(bus.empty), 1);
        set(0, 0, 4'h0); step();

        // Reset with data stored and a write request pending.
        for (int i = 0; i < 7; i++) begin
            set(1, 0, 4'(i + 1)); step();
        end
        chk("pre_rst_cnt", 32'(bus.data_count), 7);
        set(0, 1, 4'h0); step();
        chk("pre_rst_dout", 32'(bus.dout), 1);
        srst_n = 1'b0; set(1, 1, 4'hC); step();
        srst_n = 1'b1; set(0, 0, 4'h0);
        chk("mid_rst_cnt", 32'(bus.data_count), 0); chk("mid_rst_empty", 32'(bus.empty), 1);
        chk("mid_rst_dout", 32'(bus.dout), 0); chk("mid_rst_valid", 32'(bus.valid), 0);
        chk("mid_rst_flags", {29'd0, bus.full, bus.overflow, bus.underflow}, 0);
        step();
        chk("post_rst_flags", {30'd0, bus.overflow, bus.underflow}, 0);
        set(1, 0, 4'h3); step();
        chk("post_rst_cnt", 32'(bus.data_count), 1);
        set(0, 1, 4'h0); step();
        chk("post_rst_dout", 32'(bus.dout), 3); chk("post_rst_valid", 32'(bus.valid), 1);
        chk("post_rst_empty", 32'(bus.empty), 1);
        set(0, 0, 4'h0); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d/%0d passed so far", n_pass, n_chk);
        $fatal(1);
    end
endmodule
